// File: rtl/fault_sim_pkg.sv
// Shared definitions for the fault simulation sweep controller:
// FSM state encoding, default geometry and the result-count width helper.
package fault_sim_pkg;

    localparam int DEF_NUM_FAULTS = 6;
    localparam int DEF_TV_W       = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        WAIT   = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Bits needed to hold a count of 0..n detected faults.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fsim_popcount.sv
// Combinational population count of an N-bit vector into a W-bit result.
module fsim_popcount #(
    parameter int N = 6,
    parameter int W = 3
) (
    input  logic [N-1:0] bits,
    output logic [W-1:0] count
);

    // Sum the set bits one at a time.
    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + W'(bits[i]);
        end
    end

endmodule

// File: rtl/fault_sim_ctrl.sv
// Exhaustive test-vector sweep controller for a fault-simulation setup.
// Applies every vector 0 .. 2**TV_W-1 to one fault-free and NUM_FAULTS faulty
// circuit copies, lets them settle, then compares outputs to accumulate the
// detected-fault mask, coverage count and best-detecting vector.
// Optional macro FSIM_FIRST_DET_EN adds per-fault first-detecting-vector
// capture on first_tv/first_vld; without it those ports read as zero.
//
// Handshake: start is a level. It is accepted on any rising edge where the
// controller is in IDLE or DONE; busy is high from the next cycle until the
// sweep ends, done pulses for exactly one cycle, and start is ignored while
// busy. Results hold from done until the next accepted start.
module fault_sim_ctrl
    import fault_sim_pkg::*;
#(
    parameter int NUM_FAULTS = DEF_NUM_FAULTS,
    parameter int TV_W       = DEF_TV_W,
    parameter int SETTLE     = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic [TV_W-1:0]                     tv,
    input  logic [1:0]                          y_good,
    input  logic [2*NUM_FAULTS-1:0]             y_fault,
    output logic                                busy,
    output logic                                done,
    output logic [NUM_FAULTS-1:0]               det_mask,
    output logic [cnt_width(NUM_FAULTS)-1:0]    cov_cnt,
    output logic [TV_W-1:0]                     best_tv,
    output logic [cnt_width(NUM_FAULTS)-1:0]    best_cnt,
    output logic [NUM_FAULTS*TV_W-1:0]          first_tv,
    output logic [NUM_FAULTS-1:0]               first_vld,
    output logic [2:0]                          state_dbg
);

    localparam int CNT_W = cnt_width(NUM_FAULTS);
    // Last value of the settle counter before sampling; unused when SETTLE=0.
    localparam logic [3:0] SETTLE_LAST = 4'((SETTLE == 0) ? 0 : SETTLE - 1);

    state_t                state;
    state_t                state_next;
    logic                  accept;
    logic                  last_tv;
    logic [3:0]            wait_cnt;
    logic [NUM_FAULTS-1:0] det;
    logic [CNT_W-1:0]      det_cnt;

    assign last_tv   = (tv == {TV_W{1'b1}});
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, start acceptance and status decode.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = APPLY;
                end
            end
            APPLY: begin
                busy       = 1'b1;
                state_next = (SETTLE == 0) ? SAMPLE : WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (wait_cnt == SETTLE_LAST) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                busy       = 1'b1;
                state_next = last_tv ? DONE : APPLY;
            end
            DONE: begin
                // A start still held here rolls straight into the next sweep.
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = APPLY;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Settle counter: counts cycles spent in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Per-fault detection: any output bit differing from the good copy.
    always_comb begin
        det = '0;
        for (int i = 0; i < NUM_FAULTS; i++) begin
            det[i] = |(y_good ^ y_fault[2*i +: 2]);
        end
    end

    fsim_popcount #(.N(NUM_FAULTS), .W(CNT_W)) u_pop_det (
        .bits  (det),
        .count (det_cnt)
    );

    fsim_popcount #(.N(NUM_FAULTS), .W(CNT_W)) u_pop_cov (
        .bits  (det_mask),
        .count (cov_cnt)
    );

    // Vector stepping and result accumulation; outputs only observed in SAMPLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            tv       <= '0;
            det_mask <= '0;
            best_tv  <= '0;
            best_cnt <= '0;
        end else if (accept) begin
            tv       <= '0;
            det_mask <= '0;
            best_tv  <= '0;
            best_cnt <= '0;
        end else if (state == SAMPLE) begin
            det_mask <= det_mask | det;
            // Strict compare keeps the lowest vector on a tie.
            if (det_cnt > best_cnt) begin
                best_tv  <= tv;
                best_cnt <= det_cnt;
            end
            if (!last_tv) begin
                tv <= tv + 1'b1;
            end
        end
    end

`ifdef FSIM_FIRST_DET_EN
    // Capture the first vector that exposes each fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_tv  <= '0;
            first_vld <= '0;
        end else if (accept) begin
            first_tv  <= '0;
            first_vld <= '0;
        end else if (state == SAMPLE) begin
            for (int i = 0; i < NUM_FAULTS; i++) begin
                if (det[i] && !first_vld[i]) begin
                    first_tv[i*TV_W +: TV_W] <= tv;
                    first_vld[i]             <= 1'b1;
                end
            end
        end
    end
`else
    assign first_tv  = '0;
    assign first_vld = '0;
`endif

endmodule
